uart_rx_cfg: RTL
================

# uart_rx_cfg

Parametrised UART receiver: recovers serial frames of 5–9 data bits, optional parity and 1 or 2 stop bits, using an externally supplied oversampling tick. It sits between the pad-side RxD pin and a host-side valid/ready consumer. It reports framing, parity, break and overrun conditions alongside each received word. It replaces the fixed-format 8N1 receiver in new designs.

## Interface
- DATA_BITS, 8, data bits per frame, 5..9, LSB first on the wire
- STOP_BITS, 1, stop bits checked, 1 or 2
- OVERSAMPLE, 16, ticks per bit, power of two, 8..32
- PARITY, 0, 0 none / 1 odd / 2 even; honoured only with the parity feature compiled in
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- tick  in  1  one-cycle oversampling strobe at OVERSAMPLE × baud
- rxd  in  1  asynchronous serial input, idle high
- rx_data  out  DATA_BITS  received word, held while rx_valid
- rx_valid  out  1  word available
- rx_ready  in  1  consumer accepts word when rx_valid & rx_ready
- frame_err  out  1  stop bit sampled 0; qualifies rx_data
- parity_err  out  1  parity mismatch; qualifies rx_data
- break_det  out  1  all data bits, parity and stop sampled 0; qualifies rx_data
- overrun  out  1  sticky: a frame completed while the previous word was unaccepted

## Operation
- Input path: 2-flop synchroniser advanced on tick; 2-bit saturating filter; filtered bit goes to 0 at count 3 and to 1 at count 0, otherwise holds. Single-tick glitches never change the filtered bit.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: the phase counter is held at 0. A filtered 0 moves the FSM to START.
- START: count OVERSAMPLE/2 ticks to mid-bit.
  - Filtered bit still 0: go to DATA with the phase counter cleared.
  - Filtered bit 1: false start; go to IDLE with no output.
- DATA: sample on each tick where the phase counter wraps (every OVERSAMPLE ticks). Shift right into a DATA_BITS register. After DATA_BITS samples, go to PARITY if enabled, else STOP.
- PARITY: sample one bit. The error condition is XOR(data, parity bit) = 0 for odd parity, or 1 for even parity.
- STOP: sample STOP_BITS bits. Any 0 sets frame_err. After the final sample, deliver the word and go to IDLE immediately; the next start edge is accepted half a bit early.
- Delivery:
  - Output free (rx_valid=0, or rx_ready=1 in the same cycle): load rx_data and the three error flags, assert rx_valid.
  - Output occupied: discard the new word, keep the old word and flags, set overrun.
- Handshake: rx_valid deasserts in the cycle after rx_valid & rx_ready unless a new word loads in that same cycle. overrun clears on a handshake; a simultaneous new overrun wins.
- break_det implies frame_err. After a break, the FSM stays in IDLE until the filtered bit returns to 1.
- Reset mid-frame:
  - Aborts the frame; FSM goes to IDLE.
  - Synchroniser and filter reload to idle-high.
  - No word is delivered.

## Timing
- Reset values: rx_data 0, rx_valid 0, frame_err 0, parity_err 0, break_det 0, overrun 0.
- All state advances only on cycles with tick=1, except handshake logic, which is evaluated every clock.
- Output latency: rx_valid rises on the clock after the tick carrying the last stop-bit sample.
- Filter delay: 4 ticks from synchroniser output to the filtered-bit change. All sample points are centred relative to the filtered bit.
- Phase counter width is $clog2(OVERSAMPLE) and wraps naturally.
- Frame length is 1 + DATA_BITS + P + STOP_BITS bits, where P is 1 with parity and 0 without.

## Configuration
- UART_RX_PARITY_EN defined:
  - PARITY parameter is honoured, PARITY state exists, parity_err is live.
  - PARITY=0 skips the PARITY state.
- UART_RX_PARITY_EN undefined:
  - PARITY state and parity logic are removed; PARITY is ignored.
  - Frames never contain a parity bit; parity_err is tied 0.

## Structure
- Shared package uart_pkg:
  - FSM state enum.
  - Parity encoding constants PAR_NONE, PAR_ODD, PAR_EVEN.
  - Filter threshold constants.
- Sub-module uart_rx_filter contains the synchroniser and saturating filter: inputs clock, reset, tick, rxd; output filtered bit.

## Test plan
- 8N1, OVERSAMPLE=16, frame 0x55 with rx_ready=1 → rx_data=0x55, one-cycle rx_valid, all error flags 0.
- 7E1 (parity compiled in), frame 0x41 with wrong parity bit → rx_data=0x41, parity_err=1, frame_err=0.
- 8N2, second stop bit driven 0 → frame_err=1, break_det=0; with line held low 12 bits → break_det=1, frame_err=1, no further words until line returns high.
- rx_ready=0, two back-to-back frames 0xA5 then 0x3C → rx_data stays 0xA5 and overrun=1; on handshake rx_valid=0 and overrun=0.
- Low glitch of 1 tick, then a low of OVERSAMPLE/4 ticks → no START-to-DATA transition, rx_valid stays 0.
- Reset asserted mid-DATA, then a clean frame 0x81 → no word from the aborted frame; next word 0x81 with flags 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: FSM states,
// parity encodings and input-filter thresholds.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Saturating filter: the bit flips low only at full count, high only at zero.
    localparam logic [1:0] FILT_CNT_MAX = 2'd3;
    localparam logic [1:0] FILT_LOW_AT  = 2'd3;
    localparam logic [1:0] FILT_HIGH_AT = 2'd0;

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Host-side word interface of the UART receiver: data/flags with a
// valid/ready handshake. master = receiver, slave = consumer.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 break_det;
    logic                 overrun;

    modport master (
        output rx_data, rx_valid, frame_err, parity_err, break_det, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, parity_err, break_det, overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_filter.sv
// RxD input conditioning: tick-advanced synchroniser followed by a 2-bit
// saturating glitch filter. Everything reloads to the idle-high line state.
module uart_rx_filter
    import uart_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic rxd,
    output logic filt
);
    localparam int SYNC_STAGES = 2;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] stage_in;
    logic [1:0]             cnt_reg;
    logic                   filt_reg;

    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        if (gi == 0) begin : g_first
            assign stage_in[gi] = rxd;
        end else begin : g_next
            assign stage_in[gi] = sync_reg[gi-1];
        end
    end

    // The filtered bit follows the count of the previous tick, so a change
    // needs three consecutive equal samples plus one tick of decision.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_reg <= '1;
            cnt_reg  <= FILT_HIGH_AT;
            filt_reg <= 1'b1;
        end else if (tick) begin
            sync_reg <= stage_in;
            if (!sync_reg[SYNC_STAGES-1] && cnt_reg != FILT_CNT_MAX) begin
                cnt_reg <= cnt_reg + 2'd1;
            end else if (sync_reg[SYNC_STAGES-1] && cnt_reg != 2'd0) begin
                cnt_reg <= cnt_reg - 2'd1;
            end
            if (cnt_reg == FILT_LOW_AT) begin
                filt_reg <= 1'b0;
            end else if (cnt_reg == FILT_HIGH_AT) begin
                filt_reg <= 1'b1;
            end
        end
    end

    assign filt = filt_reg;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver (5..9 data bits, optional parity, 1/2 stop bits).
// Parity support is compiled in only when UART_RX_PARITY_EN is defined.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            tick,
    input  logic            rxd,
    uart_rx_cfg_if.master   rx_if
);
    localparam int PW = $clog2(OVERSAMPLE);
    localparam int CW = $clog2(DATA_BITS);
    localparam logic [PW-1:0] PH_HALF_LAST = PW'(OVERSAMPLE / 2 - 1);
    localparam logic [PW-1:0] PH_LAST      = PW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] DATA_LAST    = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] STOP_LAST    = CW'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_cfg: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end
    if (OVERSAMPLE < 8 || OVERSAMPLE > 32 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_os
        $error("uart_rx_cfg: OVERSAMPLE must be a power of two in 8..32");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_parity
        $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
    end

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_USED = (PARITY == PAR_ODD) || (PARITY == PAR_EVEN);
`endif

    logic filt;

    uart_rx_filter u_filter (
        .clock (clock),
        .reset (reset),
        .tick  (tick),
        .rxd   (rxd),
        .filt  (filt)
    );

    rx_state_t            state_reg,     state_next;
    logic [PW-1:0]        phase_reg,     phase_next;
    logic [CW-1:0]        bit_cnt_reg,   bit_cnt_next;
    logic [DATA_BITS-1:0] shift_reg,     shift_next;
    logic                 ferr_reg,      ferr_next;
    logic                 any_one_reg,   any_one_next;
    logic                 hold_high_reg, hold_high_next;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit_reg,   par_bit_next;
`endif

    logic deliver;
    logic word_fe;
    logic word_pe;
    logic word_brk;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            phase_reg     <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            ferr_reg      <= 1'b0;
            any_one_reg   <= 1'b0;
            hold_high_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_reg   <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            phase_reg     <= phase_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            ferr_reg      <= ferr_next;
            any_one_reg   <= any_one_next;
            hold_high_reg <= hold_high_next;
`ifdef UART_RX_PARITY_EN
            par_bit_reg   <= par_bit_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        phase_next     = phase_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        ferr_next      = ferr_reg;
        any_one_next   = any_one_reg;
        hold_high_next = hold_high_reg;
`ifdef UART_RX_PARITY_EN
        par_bit_next   = par_bit_reg;
`endif
        deliver        = 1'b0;
        word_fe        = 1'b0;
        word_brk       = 1'b0;

        if (tick) begin
            case (state_reg)
                ST_IDLE: begin
                    phase_next   = '0;
                    bit_cnt_next = '0;
                    // After a break the line must go high before a new start counts.
                    if (hold_high_reg) begin
                        if (filt) begin
                            hold_high_next = 1'b0;
                        end
                    end else if (!filt) begin
                        state_next   = ST_START;
                        ferr_next    = 1'b0;
                        any_one_next = 1'b0;
                    end
                end
                ST_START: begin
                    if (phase_reg == PH_HALF_LAST) begin
                        phase_next = '0;
                        state_next = filt ? ST_IDLE : ST_DATA;
                    end else begin
                        phase_next = phase_reg + 1'b1;
                    end
                end
                ST_DATA: begin
                    phase_next = phase_reg + 1'b1;
                    if (phase_reg == PH_LAST) begin
                        shift_next   = {filt, shift_reg[DATA_BITS-1:1]};
                        any_one_next = any_one_reg | filt;
                        if (bit_cnt_reg == DATA_LAST) begin
                            bit_cnt_next = '0;
`ifdef UART_RX_PARITY_EN
                            state_next   = PAR_USED ? ST_PARITY : ST_STOP;
`else
                            state_next   = ST_STOP;
`endif
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    phase_next = phase_reg + 1'b1;
                    if (phase_reg == PH_LAST) begin
                        par_bit_next = filt;
                        any_one_next = any_one_reg | filt;
                        state_next   = ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    phase_next = phase_reg + 1'b1;
                    if (phase_reg == PH_LAST) begin
                        ferr_next    = ferr_reg | ~filt;
                        any_one_next = any_one_reg | filt;
                        if (bit_cnt_reg == STOP_LAST) begin
                            deliver        = 1'b1;
                            word_fe        = ferr_reg | ~filt;
                            word_brk       = ~(any_one_reg | filt);
                            hold_high_next = word_brk;
                            bit_cnt_next   = '0;
                            phase_next     = '0;
                            state_next     = ST_IDLE;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    phase_next = '0;
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    // Odd parity errors on an even total of ones, even parity on an odd total.
    assign word_pe = PAR_USED && ((PARITY == PAR_ODD) ? ~(^{shift_reg, par_bit_reg})
                                                      :  (^{shift_reg, par_bit_reg}));
`else
    assign word_pe = 1'b0;
`endif

    logic [DATA_BITS-1:0] data_out_reg;
    logic                 valid_reg;
    logic                 fe_out_reg;
    logic                 pe_out_reg;
    logic                 brk_out_reg;
    logic                 overrun_reg;
    logic                 out_free;
    logic                 handshake;

    assign out_free  = ~valid_reg | rx_if.rx_ready;
    assign handshake = valid_reg & rx_if.rx_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            data_out_reg <= '0;
            valid_reg    <= 1'b0;
            fe_out_reg   <= 1'b0;
            pe_out_reg   <= 1'b0;
            brk_out_reg  <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            if (deliver && out_free) begin
                data_out_reg <= shift_reg;
                valid_reg    <= 1'b1;
                fe_out_reg   <= word_fe;
                pe_out_reg   <= word_pe;
                brk_out_reg  <= word_brk;
            end else if (handshake) begin
                valid_reg <= 1'b0;
            end
            if (deliver && !out_free) begin
                overrun_reg <= 1'b1;
            end else if (handshake) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign rx_if.rx_data    = data_out_reg;
    assign rx_if.rx_valid   = valid_reg;
    assign rx_if.frame_err  = fe_out_reg;
    assign rx_if.parity_err = pe_out_reg;
    assign rx_if.break_det  = brk_out_reg;
    assign rx_if.overrun    = overrun_reg;

endmodule
